// File: rtl/lanectrl_pause_sync_multi.sv
// Multi-lane HS_IO_CLK_PAUSE synchroniser with per-lane minimum pause width,
// post-pause low holdoff and optional falling-edge output retiming.
module lanectrl_pause_sync_multi #(
  parameter int unsigned NUM_LANES        = 4,
  parameter int unsigned SYNC_STAGES      = 2,
  parameter int unsigned MIN_PAUSE_CYCLES = 2,
  parameter int unsigned HOLDOFF_CYCLES   = 2,
  parameter bit          FALL_OUTPUT      = 1'b0
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [NUM_LANES-1:0] HS_IO_CLK_PAUSE,
  input  logic [NUM_LANES-1:0] LANE_EN,
  output logic [NUM_LANES-1:0] HS_IO_CLK_PAUSE_SYNC,
  output logic [NUM_LANES-1:0] STRETCH_EVT,
  output logic                 PAUSE_ANY
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(MIN_PAUSE_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLDOFF_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  logic [NUM_LANES-1:0] r_sync [SYNC_STAGES];
  logic [NUM_LANES-1:0] w_s;
  logic [NUM_LANES-1:0] r_pause_q;
  logic [NUM_LANES-1:0] r_stretch_evt;
  logic [NUM_LANES-1:0] w_pause_sync;

  // Per-lane synchroniser chain, all lanes in parallel
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int k = 0; k < int'(SYNC_STAGES); k++) r_sync[k] <= '0;
    end else begin
      r_sync[0] <= HS_IO_CLK_PAUSE;
      for (int k = 1; k < int'(SYNC_STAGES); k++) r_sync[k] <= r_sync[k-1];
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  for (genvar i = 0; i < int'(NUM_LANES); i++) begin : g_lane
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_hcnt;
    logic             r_stretch;

    // cnt counts completed high output cycles; hcnt counts remaining forced-low cycles
    always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
        r_state          <= ST_IDLE;
        r_cnt            <= '0;
        r_hcnt           <= '0;
        r_stretch        <= 1'b0;
        r_pause_q[i]     <= 1'b0;
        r_stretch_evt[i] <= 1'b0;
      end else begin
        r_stretch_evt[i] <= 1'b0;
        case (r_state)
          ST_IDLE: begin
            if (w_s[i] && LANE_EN[i]) begin
              r_state      <= ST_ASSERT;
              r_pause_q[i] <= 1'b1;
              r_cnt        <= CNT_W'(1);
              r_stretch    <= 1'b0;
            end
          end
          ST_ASSERT: begin
            if (!w_s[i] && (r_cnt >= MIN_C)) begin
              r_pause_q[i]     <= 1'b0;
              r_stretch_evt[i] <= r_stretch;
              if (HOLDOFF_CYCLES == 0) begin
                r_state <= ST_IDLE;
              end else begin
                r_state <= ST_HOLD;
                r_hcnt  <= HOLD_C;
              end
            end else begin
              if (!w_s[i] && (r_cnt < MIN_C)) r_stretch <= 1'b1;
              if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          ST_HOLD: begin
            r_hcnt <= r_hcnt - CNT_W'(1);
            if (r_hcnt <= CNT_W'(1)) begin
              if (w_s[i] && LANE_EN[i]) begin
                r_state      <= ST_ASSERT;
                r_pause_q[i] <= 1'b1;
                r_cnt        <= CNT_W'(1);
                r_stretch    <= 1'b0;
              end else begin
                r_state <= ST_IDLE;
              end
            end
          end
          default: begin
            r_state      <= ST_IDLE;
            r_pause_q[i] <= 1'b0;
          end
        endcase
      end
    end
  end

  if (FALL_OUTPUT) begin : g_fall
    logic [NUM_LANES-1:0] r_fall;
    // Half-cycle retime of the shaped pause onto the falling edge
    always_ff @(negedge CLK or posedge RESET) begin
      if (RESET) r_fall <= '0;
      else       r_fall <= r_pause_q;
    end
    assign w_pause_sync = r_fall;
  end else begin : g_rise
    assign w_pause_sync = r_pause_q;
  end

  assign HS_IO_CLK_PAUSE_SYNC = w_pause_sync;
  assign STRETCH_EVT          = r_stretch_evt;
  assign PAUSE_ANY            = |w_pause_sync;

endmodule

// File: tb/tb_lanectrl_pause_sync_multi.sv
// Directed bench for lanectrl_pause_sync_multi: default instance plus a
// falling-edge-output instance with a 3-stage synchroniser.
module tb_lanectrl_pause_sync_multi;

  logic       CLK;
  logic       RESET;
  logic [3:0] pa, ena, pb, enb;
  logic [3:0] sync_a, evt_a, sync_b, evt_b;
  logic       any_a, any_b;
  int         n_assert;
  int         n_fail;

  lanectrl_pause_sync_multi dut_a (
    .CLK(CLK), .RESET(RESET),
    .HS_IO_CLK_PAUSE(pa), .LANE_EN(ena),
    .HS_IO_CLK_PAUSE_SYNC(sync_a), .STRETCH_EVT(evt_a), .PAUSE_ANY(any_a)
  );

  lanectrl_pause_sync_multi #(.SYNC_STAGES(3), .FALL_OUTPUT(1'b1)) dut_b (
    .CLK(CLK), .RESET(RESET),
    .HS_IO_CLK_PAUSE(pb), .LANE_EN(enb),
    .HS_IO_CLK_PAUSE_SYNC(sync_b), .STRETCH_EVT(evt_b), .PAUSE_ANY(any_b)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    RESET = 1'b1;
    pa = 4'b0000; ena = 4'b1111;
    pb = 4'b0000; enb = 4'b1111;
    idle(2);
    chk("rst_sync", sync_a, 4'b0000);
    chk("rst_evt",  evt_a,  4'b0000);
    chk("rst_any",  4'(any_a), 4'd0);
    chk("rst_sync_b", sync_b, 4'b0000);
    RESET = 1'b0;
    idle(3);

    // Lane0 one-cycle request is stretched to two cycles
    pa = 4'b0001; tick(); pa = 4'b0000;
    chk("l0_e0", sync_a, 4'b0000);
    tick(); chk("l0_e1", sync_a, 4'b0000);
    tick(); chk("l0_e2", sync_a, 4'b0001); chk("l0_e2_any", 4'(any_a), 4'd1);
    chk("l0_e2_evt", evt_a, 4'b0000);
    tick(); chk("l0_e3", sync_a, 4'b0001); chk("l0_e3_evt", evt_a, 4'b0000);
    tick(); chk("l0_e4", sync_a, 4'b0000); chk("l0_e4_evt", evt_a, 4'b0001);
    tick(); chk("l0_e5_evt", evt_a, 4'b0000);
    idle(4);

    // Lane1 six-cycle request, then re-request landing in holdoff
    pa = 4'b0010; tick();
    tick(); chk("l1_e1", sync_a, 4'b0000);
    tick(); chk("l1_e2", sync_a, 4'b0010);
    tick(); tick(); tick(); pa = 4'b0000;
    tick(); pa = 4'b0010;
    tick(); chk("l1_e7", sync_a, 4'b0010);
    tick(); chk("l1_e8", sync_a, 4'b0000); chk("l1_e8_evt", evt_a, 4'b0000);
    tick(); chk("l1_e9_hold", sync_a, 4'b0000);
    tick(); chk("l1_e10_rise", sync_a, 4'b0010);
    pa = 4'b0000;
    tick(); tick(); chk("l1_e12", sync_a, 4'b0010);
    tick(); chk("l1_e13", sync_a, 4'b0000); chk("l1_e13_evt", evt_a, 4'b0000);
    idle(5);

    // Lane2 gated by LANE_EN; dropping enable mid-pause does not truncate
    ena = 4'b1011; pa = 4'b0100;
    idle(6); chk("l2_dis", sync_a, 4'b0000);
    ena = 4'b1111;
    tick(); chk("l2_e6", sync_a, 4'b0100);
    tick(); ena = 4'b1011;
    tick(); chk("l2_e8", sync_a, 4'b0100);
    pa = 4'b0000;
    tick(); tick(); chk("l2_e10", sync_a, 4'b0100);
    tick(); chk("l2_e11", sync_a, 4'b0000); chk("l2_e11_evt", evt_a, 4'b0000);
    ena = 4'b1111;
    idle(5);

    // All lanes together
    pa = 4'b1111; tick(); pa = 4'b0000;
    tick(); chk("all_e1", sync_a, 4'b0000); chk("all_e1_any", 4'(any_a), 4'd0);
    tick(); chk("all_e2", sync_a, 4'b1111); chk("all_e2_any", 4'(any_a), 4'd1);
    tick(); chk("all_e3", sync_a, 4'b1111);
    tick(); chk("all_e4", sync_a, 4'b0000); chk("all_e4_evt", evt_a, 4'b1111);
    idle(5);

    // Overlapping pulses: PAUSE_ANY covers the union
    pa = 4'b1001; tick(); pa = 4'b1000;
    tick(); tick(); chk("un_e2", sync_a, 4'b1001);
    pa = 4'b0000;
    tick(); chk("un_e3", sync_a, 4'b1001);
    tick(); chk("un_e4", sync_a, 4'b1000); chk("un_e4_any", 4'(any_a), 4'd1);
    chk("un_e4_evt", evt_a, 4'b0001);
    tick(); chk("un_e5", sync_a, 4'b0000); chk("un_e5_any", 4'(any_a), 4'd0);
    chk("un_e5_evt", evt_a, 4'b0000);
    idle(5);

    // Request exactly MIN cycles: no stretch event
    pa = 4'b0001; tick(); tick(); pa = 4'b0000;
    tick(); tick(); chk("min_e3", sync_a, 4'b0001);
    tick(); chk("min_e4", sync_a, 4'b0000); chk("min_e4_evt", evt_a, 4'b0000);
    idle(5);

    // Falling-edge output, 3 sync stages
    pb = 4'b0001; tick(); pb = 4'b0000;
    tick(); tick();
    tick(); chk("fb_e3", sync_b, 4'b0000);
    @(negedge CLK); #1; chk("fb_n3", sync_b, 4'b0001); chk("fb_n3_any", 4'(any_b), 4'd1);
    tick(); chk("fb_e4", sync_b, 4'b0001);
    tick(); chk("fb_e5", sync_b, 4'b0001); chk("fb_e5_evt", evt_b, 4'b0001);
    @(negedge CLK); #1; chk("fb_n5", sync_b, 4'b0000); chk("fb_n5_any", 4'(any_b), 4'd0);
    idle(5);

    // Asynchronous reset mid-pause, request held through release
    pa = 4'b0001; tick(); tick();
    tick(); chk("rs_e2", sync_a, 4'b0001);
    RESET = 1'b1; #1;
    chk("rs_async", sync_a, 4'b0000); chk("rs_async_any", 4'(any_a), 4'd0);
    chk("rs_async_evt", evt_a, 4'b0000);
    tick(); chk("rs_hold", sync_a, 4'b0000);
    RESET = 1'b0;
    tick(); chk("rs_e0", sync_a, 4'b0000);
    tick(); chk("rs_e1", sync_a, 4'b0000);
    tick(); chk("rs_e2b", sync_a, 4'b0001);
    pa = 4'b0000;
    idle(6); chk("rs_end", sync_a, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/lanectrl_pause_sync_multi.md
Name: lanectrl_pause_sync_multi

Overview:
Multi-lane successor to the single-lane HS_IO_CLK_PAUSE synchroniser, used by the DDR PHY lane controllers (ADDR_CMD and DQ lanes).
- Each lane's pause request passes through a configurable-depth synchroniser.
- A per-lane state machine then enforces a minimum pause width (stretching short requests) and a minimum low gap between pauses.
- The registered result drives each lane's HS_IO_CLK_PAUSE_SYNC, optionally re-timed on the falling edge.

Parameters:
NUM_LANES, 4, number of independent pause lanes (1..16)
SYNC_STAGES, 2, synchroniser flops per lane (1..4)
MIN_PAUSE_CYCLES, 2, minimum output high width in CLK cycles (1..15)
HOLDOFF_CYCLES, 2, forced output low cycles after each pause (0..15)
FALL_OUTPUT, 0, 1 = add a final CLK-falling-edge output flop per lane

Ports:
CLK  input  1  clock
RESET  input  1  asynchronous, active-high reset
HS_IO_CLK_PAUSE  input  NUM_LANES  per-lane pause request; must be held for at least 1 CLK period
LANE_EN  input  NUM_LANES  per-lane enable for starting new pauses
HS_IO_CLK_PAUSE_SYNC  output  NUM_LANES  per-lane synchronised, shaped pause
STRETCH_EVT  output  NUM_LANES  one-cycle pulse when a pause was extended to MIN_PAUSE_CYCLES
PAUSE_ANY  output  1  OR of all HS_IO_CLK_PAUSE_SYNC bits

Behaviour:
- RESET (asynchronous): clears all of the following to 0:
  - sync flops, FSM state (IDLE), counters, pause_q, stretch flag, STRETCH_EVT, fall flop.
  - HS_IO_CLK_PAUSE_SYNC = 0, STRETCH_EVT = 0, PAUSE_ANY = 0 while RESET is high.
- Synchroniser: s[i] is the output of SYNC_STAGES rising-edge flops. The FSM at edge Ek sees the input sampled at E(k-SYNC_STAGES).
- Per-lane FSM on the CLK rising edge, with registered output pause_q:
  - IDLE: pause_q = 0. If s && LANE_EN, go to ASSERT; pause_q <= 1, cnt <= 1, stretch flag <= 0.
  - ASSERT: pause_q = 1.
    - If s = 0 and cnt < MIN_PAUSE_CYCLES, set the stretch flag.
    - If cnt >= MIN_PAUSE_CYCLES and s = 0, leave ASSERT: pause_q <= 0 and STRETCH_EVT <= stretch flag for one cycle. Go to HOLDOFF with hcnt <= HOLDOFF_CYCLES, or to IDLE if HOLDOFF_CYCLES = 0.
    - Otherwise stay, with cnt saturating at 15.
  - HOLDOFF: pause_q = 0 and s is ignored. hcnt decrements each edge. On the edge where hcnt = 1: go to ASSERT (same load as from IDLE) if s && LANE_EN, otherwise go to IDLE. This gives exactly HOLDOFF_CYCLES low cycles minimum.
- LANE_EN affects only the IDLE/HOLDOFF entry into ASSERT. Dropping LANE_EN during ASSERT does not truncate the pause; it ends normally.
- Latency:
  - Rising edge of HS_IO_CLK_PAUSE to pause_q: SYNC_STAGES+1 edges. A request held N >= MIN cycles yields exactly N output cycles.
  - A request with N < MIN yields MIN output cycles and a STRETCH_EVT pulse.
- Output path:
  - FALL_OUTPUT = 0: HS_IO_CLK_PAUSE_SYNC = pause_q.
  - FALL_OUTPUT = 1: a falling-edge flop captures pause_q, adding half a cycle of latency. Its asynchronous reset is RESET.
- PAUSE_ANY is combinational OR of the registered HS_IO_CLK_PAUSE_SYNC bits.
- Lanes are fully independent; simultaneous events on different lanes do not interact.
- Counter widths are 4 bits each.
- RESET asserted mid-pause drops the output immediately with no stretch. After release, a still-high request starts a fresh pause after SYNC_STAGES+1 edges.

Test Plan:
- Defaults, lane0 request high for 1 cycle sampled at E0 -> SYNC[0] high from E2 to E4 (2 cycles); STRETCH_EVT[0] pulses one cycle from E4; other lanes stay 0.
- Lane1 request high for 6 cycles (E0..E5) -> SYNC[1] high E2..E8 (6 cycles), STRETCH_EVT[1] stays 0. Re-request at E6 -> next rise is no earlier than E8+2 = E10 (HOLDOFF_CYCLES = 2).
- LANE_EN[2] = 0 with request high -> SYNC[2] stays 0. Raise LANE_EN[2] at E5 with request still high -> SYNC[2] rises at E6. Drop LANE_EN[2] at E7 -> pulse continues until the request low is seen.
- All 4 lanes requesting on the same cycle -> all SYNC bits rise together at E2; PAUSE_ANY high for the union of the pulses.
- FALL_OUTPUT = 1, SYNC_STAGES = 3 -> SYNC rises on the falling edge after E3; widths are unchanged.
- RESET pulsed while lane0 is in ASSERT at cnt = 1 -> SYNC[0], PAUSE_ANY and STRETCH_EVT go to 0 asynchronously. Request held high after release -> rises SYNC_STAGES+1 edges later.
